// File: rtl/decade_sequence_monitor.sv
// -----------------------------------------------------------------------------
// decade_sequence_monitor
//
// Receive-side monitor for a decade counter's one-hot output bus. The
// 10-bit position and the Q5-9 carry line come from an asynchronous source.
// They are resynchronised, qualified for stability and checked against the
// legal counting sequence. The monitor produces a clean BCD digit, event
// pulses and a BCD count of decade wraps. Any illegal code or sequence
// latches a sticky fault.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth (>= 2)
//   DECADES      number of BCD digits in the wrap counter
//
// Ports:
//   cp0          clock
//   mr           synchronous active-high reset (overrides everything)
//   in_q         one-hot decade position, bit n = position n
//   in_q59_n     carry line, high while position is 0..4
//   clr_fault    clears a latched fault and returns to hunting
//   digit        BCD of the current accepted position
//   digit_valid  high while tracking
//   step         pulse per legal +1 advance (including 9->0)
//   wrap         pulse on the 9->0 advance, coincident with step
//   restart      pulse when position jumps to 0 from anything but 9
//   tens         BCD wrap count, rolls over from all-9s to 0
//   fault        sticky fault flag
//   fault_code   00 none, 01 not one-hot, 10 illegal jump, 11 carry mismatch
// -----------------------------------------------------------------------------
module decade_sequence_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int DECADES     = 2
) (
  input  logic                   cp0,
  input  logic                   mr,
  input  logic [9:0]             in_q,
  input  logic                   in_q59_n,
  input  logic                   clr_fault,
  output logic [3:0]             digit,
  output logic                   digit_valid,
  output logic                   step,
  output logic                   wrap,
  output logic                   restart,
  output logic [4*DECADES-1:0]   tens,
  output logic                   fault,
  output logic [1:0]             fault_code
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ONEHOT  = 2'b01;
  localparam logic [1:0] CODE_JUMP    = 2'b10;
  localparam logic [1:0] CODE_CARRY   = 2'b11;

  // ---------------------------------------------------------------------------
  // Synchroniser: carry line and position travel together as one 11-bit word.
  // ---------------------------------------------------------------------------
  logic [10:0] r_sync [SYNC_STAGES];
  logic [10:0] r_prev;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge cp0) begin
          if (mr) r_sync[gi] <= '0;
          else    r_sync[gi] <= {in_q59_n, in_q};
        end
      end else begin : g_rest
        always_ff @(posedge cp0) begin
          if (mr) r_sync[gi] <= '0;
          else    r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  // Stability qualifier: a sample is trusted only when it matches the previous
  // cycle's sample, so bit-skew transients between positions never reach the
  // sequence checker.
  always_ff @(posedge cp0) begin
    if (mr) r_prev <= '0;
    else    r_prev <= r_sync[SYNC_STAGES-1];
  end

  logic [10:0] w_sample;
  logic [9:0]  w_s;
  logic        w_qual;
  logic        w_onehot;
  logic        w_carry_ok;

  assign w_sample   = r_sync[SYNC_STAGES-1];
  assign w_s        = w_sample[9:0];
  assign w_qual     = (w_sample == r_prev);
  // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit.
  assign w_onehot   = (w_s != 10'd0) && ((w_s & (w_s - 10'd1)) == 10'd0);
  assign w_carry_ok = (w_sample[10] == ~|w_s[9:5]);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t              r_state, w_state_next;
  logic [9:0]          r_pos, w_pos_next;
  logic [3:0]          r_digit, w_digit_next;
  logic                r_step, w_step_next;
  logic                r_wrap, w_wrap_next;
  logic                r_restart, w_restart_next;
  logic [4*DECADES-1:0] r_tens, w_tens_next;
  logic [1:0]          r_code, w_code_next;

  logic [9:0]          w_rotl;
  logic [4*DECADES-1:0] w_tens_inc;

  assign w_rotl = {r_pos[8:0], r_pos[9]};

  // BCD increment of the wrap counter with ripple carry between digits.
  logic [DECADES-1:0] w_carry;
  assign w_carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DECADES; gi++) begin : g_tens
      logic [3:0] w_d;
      assign w_d = r_tens[4*gi +: 4];
      assign w_tens_inc[4*gi +: 4] = w_carry[gi] ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1) : w_d;
      if (gi < DECADES-1) begin : g_c
        assign w_carry[gi+1] = w_carry[gi] && (w_d == 4'd9);
      end
    end
  endgenerate

  always_ff @(posedge cp0) begin
    if (mr) begin
      r_state   <= HUNT;
      r_pos     <= '0;
      r_digit   <= '0;
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
      r_restart <= 1'b0;
      r_tens    <= '0;
      r_code    <= CODE_NONE;
    end else begin
      r_state   <= w_state_next;
      r_pos     <= w_pos_next;
      r_digit   <= w_digit_next;
      r_step    <= w_step_next;
      r_wrap    <= w_wrap_next;
      r_restart <= w_restart_next;
      r_tens    <= w_tens_next;
      r_code    <= w_code_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pos_next     = r_pos;
    w_digit_next   = r_digit;
    w_step_next    = 1'b0;
    w_wrap_next    = 1'b0;
    w_restart_next = 1'b0;
    w_tens_next    = r_tens;
    w_code_next    = r_code;

    case (r_state)
      HUNT: begin
        // Only a clean, qualified position 0 with the right carry arms tracking.
        if (w_qual && (w_s == 10'd1) && w_carry_ok) begin
          w_state_next = TRACK;
          w_pos_next   = 10'd1;
          w_digit_next = 4'd0;
        end
      end

      TRACK: begin
        if (w_qual) begin
          if (!w_onehot) begin
            w_state_next = FAULT;
            w_code_next  = CODE_ONEHOT;
          end else if (!w_carry_ok) begin
            w_state_next = FAULT;
            w_code_next  = CODE_CARRY;
          end else if (w_s == r_pos) begin
            // holding position
          end else if (w_s == w_rotl) begin
            w_pos_next   = w_s;
            w_digit_next = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
            w_step_next  = 1'b1;
            if (r_pos[9]) begin
              w_wrap_next = 1'b1;
              w_tens_next = w_tens_inc;
            end
          end else if ((w_s == 10'd1) && !r_pos[9] && !r_pos[0]) begin
            w_pos_next     = w_s;
            w_digit_next   = 4'd0;
            w_restart_next = 1'b1;
          end else begin
            w_state_next = FAULT;
            w_code_next  = CODE_JUMP;
          end
        end
      end

      FAULT: begin
        // Input is ignored; digit, position and tens stay frozen.
        if (clr_fault) begin
          w_state_next = HUNT;
          w_code_next  = CODE_NONE;
        end
      end

      default: begin
        w_state_next = HUNT;
      end
    endcase
  end

  assign digit       = r_digit;
  assign digit_valid = (r_state == TRACK);
  assign step        = r_step;
  assign wrap        = r_wrap;
  assign restart     = r_restart;
  assign tens        = r_tens;
  assign fault       = (r_state == FAULT);
  assign fault_code  = r_code;

endmodule

// File: doc/decade_sequence_monitor.md
# decade_sequence_monitor

Receive-side monitor for a decade-counter output bus. It samples a 10-bit one-hot decade position and its Q5–9 carry line from an asynchronous source. It resynchronises both to the local clock, qualifies each sample for stability, and decodes the position to BCD. It pulses on every legal advance, counts decade wraps in BCD, and latches a sticky fault on any illegal code or sequence. It sits between a decade counter's outputs and synchronous logic that needs a clean digit value and event pulses.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (min 2)
- DECADES, 2, number of BCD digits in the wrap counter
- cp0  in  1  clock
- mr  in  1  synchronous active-high reset
- in_q  in  10  decade position, one-hot, bit n = position n
- in_q59_n  in  1  carry line, high while position is 0–4
- clr_fault  in  1  clears fault and re-arms monitor (synchronous)
- digit  out  4  BCD of current accepted position
- digit_valid  out  1  digit is tracked and trustworthy
- step  out  1  one-cycle pulse per legal +1 advance (includes 9→0)
- wrap  out  1  one-cycle pulse on the 9→0 advance, coincident with step
- restart  out  1  one-cycle pulse when position jumps to 0 from anything but 9
- tens  out  4*DECADES  BCD count of wraps, rolls over from all-9s to 0
- fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 not one-hot, 10 illegal jump, 11 carry mismatch

## Operation
- Synchroniser: in_q and in_q59_n pass through SYNC_STAGES flops. A sample is qualified only when the synchronised 11-bit value equals the previous cycle's value. This absorbs bit-skew transients.
- Qualified sample S is checked in priority order:
  - not exactly one-hot → code 01
  - in_q59_n ≠ ~|S[9:5] → code 11
  - otherwise sequence check against P, the last accepted position
- States:
  - HUNT (reset state): digit_valid=0. Waits for qualified S = 10'b0000000001 with a correct carry; then P←S, digit←0, goes to TRACK. All other qualified values are ignored; no fault is raised in HUNT.
  - TRACK: digit_valid=1.
    - S=P: hold.
    - S=rotl(P): P←S, digit increments, step=1. If P was 9, also wrap=1 and tens increments in BCD with ripple carry.
    - S=1 with P≠9 and P≠0: P←S, digit←0, restart=1. No step, tens unchanged.
    - Any other one-hot S: code 10.
    - Check failures: go to FAULT.
  - FAULT: fault=1, fault_code latched, digit_valid=0. digit and tens are frozen. Further input is ignored. clr_fault → fault=0, code=00, go to HUNT. tens is retained.
- Only the first fault's code is latched.
- Unqualified (changing) samples never cause state change or fault.

## Timing
- Reset values:
  - digit=0, digit_valid=0, step=0, wrap=0, restart=0
  - tens=0, fault=0, fault_code=00
  - state=HUNT, synchroniser and qualifier flops = 0
- mr overrides clr_fault and all inputs on the same edge.
- mr mid-operation: all outputs take reset values on the next cp0 edge, including tens.
- Latency: input change stable before edge k → step/wrap/restart and the new digit are visible after edge k+SYNC_STAGES+1. That is 3 cycles at default.
- Fault latency equals event latency. fault rises the same cycle step would have.
- Throughput: the source must hold each position ≥ SYNC_STAGES+2 cp0 cycles. A faster source yields code 10 (skip), not silent loss.
- step, wrap and restart are single-cycle, registered, and mutually exclusive except step+wrap.
- tens update and wrap pulse take effect on the same edge. tens rollover (e.g. 99→00 at DECADES=2) gives no extra flag.
- clr_fault while a valid 0 is presented: FAULT→HUNT on edge 1, HUNT→TRACK on the next qualified sample.

## Test plan
- After reset, drive in_q=001h, q59_n=1 → digit_valid=1 at cycle 4, digit=0; all pulses 0, tens=00.
- Step 0..9 then 0, holding each position 4 cycles → ten step pulses, one wrap on 9→0 coincident with step, digit back to 0, tens=01. Repeat 100 decades → tens rolls 99→00.
- At position 6, drive 100h (position 8) → fault=1, fault_code=10, digit frozen at 6, digit_valid=0. Assert clr_fault, then drive 001h → TRACK again with tens unchanged.
- Drive 030h (two-hot) stable 3+ cycles → fault_code=01. A 1-cycle two-hot transient between 010h and 020h → no fault, single step.
- Drive 040h (position 6) with q59_n=1 → fault_code=11. Then apply mr mid-fault → all outputs at reset values next edge.
- From position 4, jump to 001h → restart pulse, digit=0, no step/wrap, tens unchanged.
